// File: rtl/seq_divider_8bit_if.sv
// Operator bus for the sequential divider.
// Switch inputs, Run/Load controls and result/status outputs.
interface seq_divider_8bit_if;
  logic       Run;
  logic       LoadHi;
  logic       LoadLo;
  logic [7:0] S;
  logic [7:0] Quot;
  logic [7:0] Rem;
  logic [7:0] DivHi;
  logic [7:0] DivLo;
  logic       Busy;
  logic       Done;
  logic       DivByZero;
  logic       Overflow;

  modport master (
    output Run, LoadHi, LoadLo, S,
    input  Quot, Rem, DivHi, DivLo,
    input  Busy, Done, DivByZero, Overflow
  );

  modport slave (
    input  Run, LoadHi, LoadLo, S,
    output Quot, Rem, DivHi, DivLo,
    output Busy, Done, DivByZero, Overflow
  );
endinterface

// File: rtl/seq_divider_8bit.sv
// Signed 16/8 restoring divider with Run/Load switch interface.
// Sign-magnitude core: divide magnitudes, then fix signs and range.
module seq_divider_8bit #(
  parameter int N_ITER = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  seq_divider_8bit_if.slave   bus
);

  localparam int CW = $clog2(N_ITER);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DIV,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [15:0] dividend_q, dividend_d;
  logic [7:0]  divisor_q, divisor_d;
  logic [7:0]  quot_q, quot_d;
  logic [7:0]  rem_q, rem_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;
  logic        sign_n_q, sign_n_d;
  logic        sign_d_q, sign_d_d;
  logic [15:0] nmag_q, nmag_d;
  logic [8:0]  dmag_q, dmag_d;
  logic [7:0]  racc_q, racc_d;
  logic [15:0] qmag_q, qmag_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [8:0]  r_shift;
  logic        r_ge;
  logic        q_neg;
  logic        q_ovf;

  // One restoring step: bring in the next dividend bit, try subtract.
  assign r_shift = {racc_q, nmag_q[15]};
  assign r_ge    = (r_shift >= dmag_q);

  assign q_neg = sign_n_q ^ sign_d_q;
  assign q_ovf = q_neg ? (qmag_q > 16'd128)
                       : (qmag_q > 16'd127);

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    sign_n_d   = sign_n_q;
    sign_d_d   = sign_d_q;
    nmag_d     = nmag_q;
    dmag_d     = dmag_q;
    racc_d     = racc_q;
    qmag_d     = qmag_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.Run) begin
          state_d   = SETUP;
          divisor_d = bus.S;
          dbz_d     = 1'b0;
          ovf_d     = 1'b0;
        end else begin
          if (bus.LoadHi) dividend_d[15:8] = bus.S;
          if (bus.LoadLo) dividend_d[7:0]  = bus.S;
        end
      end

      SETUP: begin
        sign_n_d = dividend_q[15];
        sign_d_d = divisor_q[7];
        nmag_d   = dividend_q[15]
                 ? 16'd0 - dividend_q
                 : dividend_q;
        // Sign-extend before negating so -128 becomes +128.
        dmag_d   = divisor_q[7]
                 ? 9'd0 - {divisor_q[7], divisor_q}
                 : {1'b0, divisor_q};
        racc_d   = 8'd0;
        qmag_d   = 16'd0;
        cnt_d    = '0;
        if (divisor_q == 8'd0) begin
          quot_d  = 8'hFF;
          rem_d   = dividend_q[7:0];
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = DIV;
        end
      end

      DIV: begin
        racc_d = r_ge ? 8'(r_shift - dmag_q)
                      : r_shift[7:0];
        qmag_d = {qmag_q[14:0], r_ge};
        nmag_d = {nmag_q[14:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(N_ITER - 1))
          state_d = FIX;
      end

      FIX: begin
        if (q_ovf) begin
          ovf_d  = 1'b1;
          quot_d = q_neg ? 8'h80 : 8'h7F;
          rem_d  = 8'h00;
        end else begin
          quot_d = q_neg ? 8'(16'd0 - qmag_q)
                         : qmag_q[7:0];
          rem_d  = sign_n_q ? 8'd0 - racc_q
                            : racc_q;
        end
        state_d = DONE;
      end

      DONE: begin
        if (!bus.Run)
          state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      dividend_q <= 16'd0;
      divisor_q  <= 8'd0;
      quot_q     <= 8'd0;
      rem_q      <= 8'd0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      sign_n_q   <= 1'b0;
      sign_d_q   <= 1'b0;
      nmag_q     <= 16'd0;
      dmag_q     <= 9'd0;
      racc_q     <= 8'd0;
      qmag_q     <= 16'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      sign_n_q   <= sign_n_d;
      sign_d_q   <= sign_d_d;
      nmag_q     <= nmag_d;
      dmag_q     <= dmag_d;
      racc_q     <= racc_d;
      qmag_q     <= qmag_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.Quot      = quot_q;
  assign bus.Rem       = rem_q;
  assign bus.DivHi     = dividend_q[15:8];
  assign bus.DivLo     = dividend_q[7:0];
  assign bus.DivByZero = dbz_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Done      = (state_q == DONE);
  assign bus.Busy      = (state_q == SETUP) ||
                         (state_q == DIV)   ||
                         (state_q == FIX);

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Bench for seq_divider_8bit: directed edges plus random operands
// checked against an integer-division reference.
module tb_seq_divider_8bit;

  logic clk;
  logic rst;

  seq_divider_8bit_if dif();

  seq_divider_8bit dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  logic [7:0] prev_q;
  logic [7:0] prev_r;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(
    input  logic [15:0] n,
    input  logic [7:0]  d,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        ov,
    output logic        dz
  );
    int ni, di, qi, ri;
    ni = $signed(n);
    di = $signed(d);
    ov = 1'b0;
    dz = 1'b0;
    if (di == 0) begin
      q  = 8'hFF;
      r  = n[7:0];
      dz = 1'b1;
    end else begin
      qi = ni / di;
      ri = ni % di;
      if (qi > 127) begin
        q = 8'h7F; r = 8'h00; ov = 1'b1;
      end else if (qi < -128) begin
        q = 8'h80; r = 8'h00; ov = 1'b1;
      end else begin
        q = qi[7:0];
        r = ri[7:0];
      end
    end
  endfunction

  task automatic load(input logic [15:0] n);
    @(negedge clk);
    dif.S = n[15:8];
    dif.LoadHi = 1'b1;
    @(negedge clk);
    dif.LoadHi = 1'b0;
    dif.S = n[7:0];
    dif.LoadLo = 1'b1;
    @(negedge clk);
    dif.LoadLo = 1'b0;
  endtask

  task automatic do_div(
    input logic [15:0] n,
    input logic [7:0]  d,
    input bit          poke
  );
    logic [7:0] eq, er;
    logic eov, edz;
    int cyc;
    ref_div(n, d, eq, er, eov, edz);
    load(n);
    chk("div_hi_ld", dif.DivHi, n[15:8]);
    chk("div_lo_ld", dif.DivLo, n[7:0]);
    @(negedge clk);
    dif.S = d;
    dif.Run = 1'b1;
    dif.LoadLo = poke;
    @(posedge clk);
    #1;
    chk("busy_start", dif.Busy, 1);
    chk("flags_clr", {dif.DivByZero, dif.Overflow}, 0);
    chk("quot_hold", dif.Quot, prev_q);
    chk("rem_hold", dif.Rem, prev_r);
    @(negedge clk);
    dif.LoadLo = 1'b0;
    if (poke) begin
      dif.LoadHi = 1'b1;
      dif.S = ~n[15:8];
    end
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dif.Done) break;
    end
    chk("latency", cyc, edz ? 1 : 18);
    chk("done", dif.Done, 1);
    chk("quot", dif.Quot, eq);
    chk("rem", dif.Rem, er);
    chk("ovf", dif.Overflow, eov);
    chk("dbz", dif.DivByZero, edz);
    chk("div_hi", dif.DivHi, n[15:8]);
    chk("div_lo", dif.DivLo, n[7:0]);
    @(negedge clk);
    dif.LoadHi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", {dif.Done, dif.Busy}, 2'b10);
    chk("hold_quot", dif.Quot, eq);
    @(negedge clk);
    dif.Run = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_done", {dif.Done, dif.Busy}, 2'b00);
    chk("idle_quot", dif.Quot, eq);
    chk("idle_rem", dif.Rem, er);
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic reset_mid(input logic [15:0] n, input logic [7:0] d);
    load(n);
    @(negedge clk);
    dif.S = d;
    dif.Run = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    dif.Run = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", {dif.Done, dif.Busy}, 2'b00);
    chk("rst_quot", dif.Quot, 0);
    chk("rst_rem", dif.Rem, 0);
    chk("rst_div", {dif.DivHi, dif.DivLo}, 0);
    chk("rst_flags", {dif.DivByZero, dif.Overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_q = 8'h00;
    prev_r = 8'h00;
  endtask

  logic [15:0] dn [14];
  logic [7:0]  dd [14];

  initial begin
    n_vec = 0;
    n_err = 0;
    prev_q = 8'h00;
    prev_r = 8'h00;
    dif.Run = 1'b0;
    dif.LoadHi = 1'b0;
    dif.LoadLo = 1'b0;
    dif.S = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("por_quot", dif.Quot, 0);
    chk("por_rem", dif.Rem, 0);
    chk("por_div", {dif.DivHi, dif.DivLo}, 0);
    chk("por_stat", {dif.Busy, dif.Done, dif.DivByZero, dif.Overflow}, 0);
    @(negedge clk);
    rst = 1'b0;

    dn = '{16'h019D, 16'hFE63, 16'h019D, 16'hFE63, 16'h0064,
           16'hFF9C, 16'h1000, 16'hF000, 16'h0080, 16'h0000,
           16'h1234, 16'h8000, 16'hFF80, 16'h7FFF};
    dd = '{8'h3B, 8'h3B, 8'hC5, 8'hC5, 8'h07,
           8'h07, 8'h02, 8'h02, 8'hFF, 8'h80,
           8'h00, 8'h01, 8'h01, 8'h80};
    for (int i = 0; i < 14; i++)
      do_div(dn[i], dd[i], (i % 3) == 1);

    reset_mid(16'h019D, 8'h3B);
    do_div(16'h019D, 8'h3B, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] rn;
      logic [7:0]  rd;
      rn = 16'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        rn = {{8{rn[7]}}, rn[7:0]};
      do_div(rn, rd, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
